// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;
  localparam logic [1:0] PAR_RSVD = 2'd3;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_8 = 2'd3;

  // Frame format captured when a word is popped.
  typedef struct packed {
    logic [1:0] data_bits;
    logic [1:0] parity;
    logic       two_stop;
  } frame_cfg_t;

  function automatic logic parity_enabled(input logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

  // XOR over the bits actually sent; inverted for odd mode.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] dbits,
                                      input logic [1:0] par);
    logic [7:0] mask;
    mask = 8'hFF >> (DBITS_8 - dbits);
    return (^(data & mask)) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Producer-side valid/ready byte stream into the UART transmitter.
interface uart_tx_engine_if #(
  parameter int unsigned P_DATA_WIDTH = 8
);
  logic [P_DATA_WIDTH-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and occupancy count.
module uart_sync_fifo #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 4
) (
  input  logic                       i_u_clk,
  input  logic                       i_u_rst_n,
  input  logic                       i_wr,
  input  logic [P_WIDTH-1:0]         i_wr_data,
  input  logic                       i_rd,
  output logic [P_WIDTH-1:0]         o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(P_DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      count_q;
  logic               wr_en, rd_en;

  // A full FIFO refuses writes even when a read happens on the same edge.
  assign wr_en = i_wr & ~o_full;
  assign rd_en = i_rd & ~o_empty;

  always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
    if (!i_u_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_u_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_full    = (count_q == LW'(P_DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_level   = count_q;

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: FIFO, baud down-counter, frame FSM and LSB-first shifter.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_FIFO_DEPTH = 4,
  parameter int unsigned P_DIV_WIDTH  = 16
) (
  input  logic                            i_u_clk,
  input  logic                            i_u_rst_n,
  uart_tx_engine_if.slave                 tx_if,
  input  logic [P_DIV_WIDTH-1:0]          i_cfg_div,
  input  logic [1:0]                      i_cfg_data_bits,
  input  logic [1:0]                      i_cfg_parity,
  input  logic                            i_cfg_stop,
  output logic                            o_uart_tx,
  output logic                            o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_level
);
  localparam int unsigned LVL_W = $clog2(P_FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W = P_DIV_WIDTH;

  tx_state_e             state_q, state_nxt;
  frame_cfg_t            cfg_q, cfg_in;
  logic [DIV_W-1:0]      div_q, div_in, div_cnt_q, div_cnt_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_nxt, last_idx;
  logic [7:0]            shift_q, shift_nxt, pop_byte;
  logic                  par_q, par_nxt;
  logic                  line_nxt, busy_nxt;
  logic                  bit_end, load, push;

  logic [P_DATA_WIDTH-1:0] fifo_rd_data;
  logic                    fifo_full, fifo_empty;
  logic [LVL_W-1:0]        fifo_level, level_nxt;

  uart_sync_fifo #(
    .P_WIDTH (P_DATA_WIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_u_clk   (i_u_clk),
    .i_u_rst_n (i_u_rst_n),
    .i_wr      (tx_if.tx_valid),
    .i_wr_data (tx_if.tx_data),
    .i_rd      (load),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (fifo_level)
  );

  assign tx_if.tx_ready = ~fifo_full;
  assign o_fifo_level   = fifo_level;
  assign push           = tx_if.tx_valid & ~fifo_full;
  assign level_nxt      = fifo_level + LVL_W'(push) - LVL_W'(load);

  assign div_in   = (i_cfg_div == '0) ? DIV_W'(1) : i_cfg_div;
  assign cfg_in   = '{data_bits: i_cfg_data_bits, parity: i_cfg_parity, two_stop: i_cfg_stop};
  assign pop_byte = 8'(fifo_rd_data);
  assign bit_end  = (div_cnt_q == '0);
  assign last_idx = BIT_CNT_W'(cfg_q.data_bits) + BIT_CNT_W'(4);

  // State and datapath registers
  always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
    if (!i_u_rst_n) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      div_q     <= DIV_W'(1);
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      o_uart_tx <= 1'b1;
      o_tx_busy <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      div_cnt_q <= div_cnt_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
      par_q     <= par_nxt;
      o_uart_tx <= line_nxt;
      o_tx_busy <= busy_nxt;
      if (load) begin
        cfg_q <= cfg_in;
        div_q <= div_in;
      end
    end
  end

  // Next state, bit timing and shifter
  always_comb begin
    state_nxt   = state_q;
    div_cnt_nxt = div_cnt_q;
    bit_cnt_nxt = bit_cnt_q;
    shift_nxt   = shift_q;
    load        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          div_cnt_nxt = div_q - DIV_W'(1);
          bit_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          div_cnt_nxt = div_q - DIV_W'(1);
          if (bit_cnt_q == last_idx) begin
            state_nxt   = parity_enabled(cfg_q.parity) ? ST_PARITY : ST_STOP;
            bit_cnt_nxt = '0;
          end else begin
            shift_nxt   = shift_q >> 1;
            bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt   = ST_STOP;
          div_cnt_nxt = div_q - DIV_W'(1);
          bit_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (cfg_q.two_stop && (bit_cnt_q == '0)) begin
            bit_cnt_nxt = BIT_CNT_W'(1);
            div_cnt_nxt = div_q - DIV_W'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Pop: start bit begins on this edge, frame format captured here.
    if (load) begin
      state_nxt   = ST_START;
      div_cnt_nxt = div_in - DIV_W'(1);
      bit_cnt_nxt = '0;
      shift_nxt   = pop_byte;
    end
  end

  // Line level and busy flag for the coming cycle
  always_comb begin
    par_nxt  = load ? parity_bit(pop_byte, i_cfg_data_bits, i_cfg_parity) : par_q;
    line_nxt = 1'b1;
    unique case (state_nxt)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = shift_nxt[0];
      ST_PARITY: line_nxt = par_nxt;
      default:   line_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != ST_IDLE) || (level_nxt != '0);
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine: frame waveforms, FIFO flow control, reset.
module tb_uart_tx_engine;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop;
  logic        line;
  logic        busy;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [1023:0] exp_v;
  logic [1023:0] cap_v;
  int            exp_n;

  uart_tx_engine_if #(.P_DATA_WIDTH(8)) u_if ();

  uart_tx_engine #(
    .P_DATA_WIDTH (8),
    .P_FIFO_DEPTH (4),
    .P_DIV_WIDTH  (16)
  ) dut (
    .i_u_clk         (clk),
    .i_u_rst_n       (rst_n),
    .tx_if           (u_if),
    .i_cfg_div       (cfg_div),
    .i_cfg_data_bits (cfg_data_bits),
    .i_cfg_parity    (cfg_parity),
    .i_cfg_stop      (cfg_stop),
    .o_uart_tx       (line),
    .o_tx_busy       (busy),
    .o_fifo_level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wave(input string tag);
    int bad;
    checks++;
    assert (cap_v === exp_v) else begin
      errors++;
      bad = 0;
      for (int k = exp_n - 1; k >= 0; k--) if (cap_v[k] !== exp_v[k]) bad = k;
      $error("FAIL %s first bad clock=%0d observed=%b expected=%b", tag, bad + 1, cap_v[bad], exp_v[bad]);
    end
  endtask

  task automatic exp_clear();
    exp_v = '0;
    exp_n = 0;
  endtask

  // seq holds the line bits first-bit-in-MSB, nb bits long; each bit lasts div clocks
  task automatic exp_add(input logic [15:0] seq, input int nb, input int div);
    for (int j = 0; j < nb; j++)
      for (int c = 0; c < div; c++) begin
        exp_v[exp_n] = seq[nb - 1 - j];
        exp_n++;
      end
  endtask

  // Independent frame model: start, LSB-first data, optional parity, stop bit(s)
  task automatic frame_seq(input logic [7:0] d, input int nbits, input int par, input int two_stop,
                           output logic [15:0] seq, output int nb);
    logic p;
    seq = '0; nb = 0; p = 1'b0;
    seq = {seq[14:0], 1'b0}; nb++;
    for (int i = 0; i < nbits; i++) begin
      seq = {seq[14:0], d[i]}; nb++;
      p = p ^ d[i];
    end
    if (par == 1) begin seq = {seq[14:0], ~p}; nb++; end
    if (par == 2) begin seq = {seq[14:0], p}; nb++; end
    seq = {seq[14:0], 1'b1}; nb++;
    if (two_stop != 0) begin seq = {seq[14:0], 1'b1}; nb++; end
  endtask

  // Present a word from the falling edge; it is taken on the next rising edge with ready high
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    u_if.tx_data  = b;
    u_if.tx_valid = 1'b1;
    while (!u_if.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(u_if.tx_ready), 32'd1);
    @(posedge clk);
    #1;
    u_if.tx_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_v = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cap_v[k] = line;
    end
  endtask

  // Push one word and check its whole frame, the pre-start cycle and the drop of busy
  task automatic single_frame(input string tag, input logic [7:0] b, input logic [15:0] seq,
                              input int nb, input int div);
    exp_clear();
    exp_add(seq, nb, div);
    push_byte(b);
    check({tag, "_prestart_line"}, 32'(line), 32'd1);
    check({tag, "_prestart_busy"}, 32'(busy), 32'd1);
    capture(exp_n);
    check_wave({tag, "_wave"});
    check({tag, "_laststop_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_idle_line"}, 32'(line), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0]  words [6];
  logic [15:0] sq;
  int          nbq;
  int          nwait;

  initial begin
    rst_n         = 1'b0;
    u_if.tx_data  = '0;
    u_if.tx_valid = 1'b0;
    cfg_div       = 16'd4;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    cfg_stop      = 1'b0;
    #12;
    check("rst_line",  32'(line), 32'd1);
    check("rst_ready", 32'(u_if.tx_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 div=4, 0x55: 40-clock frame
    single_frame("8n1_55", 8'h55, 16'b0101010101, 10, 4);

    // 7E1 div=2, 0x41: parity 0; then 7O1: parity 1
    cfg_div = 16'd2; cfg_data_bits = 2'd2; cfg_parity = 2'd2;
    single_frame("7e1_41", 8'h41, 16'b0100000101, 10, 2);
    cfg_parity = 2'd1;
    single_frame("7o1_41", 8'h41, 16'b0100000111, 10, 2);

    // 5N2 div=3, 0xFF: five ones, upper bits dropped, 6 clocks of stop
    cfg_div = 16'd3; cfg_data_bits = 2'd0; cfg_parity = 2'd0; cfg_stop = 1'b1;
    single_frame("5n2_ff", 8'hFF, 16'b01111111, 8, 3);

    // div=0 acts as 1 clock per bit; reserved parity code sends no parity
    cfg_div = 16'd0; cfg_data_bits = 2'd3; cfg_parity = 2'd3; cfg_stop = 1'b0;
    single_frame("div0_81", 8'h81, 16'b0100000011, 10, 1);

    // FIFO flow control: 6 words, div=16, back-to-back frames
    cfg_div = 16'd16; cfg_parity = 2'd0;
    words[0] = 8'h31; words[1] = 8'hC2; words[2] = 8'h0F;
    words[3] = 8'hF0; words[4] = 8'h99; words[5] = 8'h6A;
    exp_clear();
    for (int i = 0; i < 6; i++) begin
      frame_seq(words[i], 8, 0, 0, sq, nbq);
      exp_add(sq, nbq, 16);
    end
    push_byte(words[0]);
    fork
      begin
        for (int i = 1; i < 5; i++) push_byte(words[i]);
        @(negedge clk);
        check("fifo_full_ready", 32'(u_if.tx_ready), 32'd0);
        check("fifo_full_level", 32'(level), 32'd4);
        nwait = 0;
        do begin
          @(posedge clk);
          #1;
          nwait++;
        end while (!u_if.tx_ready && nwait < 2000);
        check("fifo_ready_rise", 32'(nwait), 32'd157);
        check("fifo_level_after_pop", 32'(level), 32'd3);
        push_byte(words[5]);
      end
      capture(960);
    join
    check_wave("fifo_b2b_wave");
    @(posedge clk);
    #1;
    check("fifo_end_busy",  32'(busy), 32'd0);
    check("fifo_end_level", 32'(level), 32'd0);
    check("fifo_end_line",  32'(line), 32'd1);

    // Format change mid-frame: first frame stays 8N1, second is 8E2
    cfg_div = 16'd2; cfg_parity = 2'd0; cfg_stop = 1'b0;
    exp_clear();
    exp_add(16'b0101001011, 10, 2);
    exp_add(16'b000111100011, 12, 2);
    push_byte(8'hA5);
    fork
      push_byte(8'h3C);
      begin
        repeat (3) @(posedge clk);
        #2;
        cfg_parity = 2'd2;
        cfg_stop   = 1'b1;
      end
      capture(44);
    join
    check_wave("cfg_change_wave");
    @(posedge clk);
    #1;
    check("cfg_change_busy", 32'(busy), 32'd0);

    // Reset in the middle of the data bits
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop = 1'b0;
    push_byte(8'h00);
    push_byte(8'h00);
    repeat (8) @(posedge clk);
    #3;
    check("prerst_line",  32'(line), 32'd0);
    check("prerst_level", 32'(level), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_line",  32'(line), 32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_ready", 32'(u_if.tx_ready), 32'd1);
    check("midrst_busy",  32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single_frame("postrst_55", 8'h55, 16'b0101010101, 10, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
